// File: rtl/input_pkg.sv
//==============================================================================
// Module : input_pkg
// Desc   : Shared constants and helpers for the pin-input debounce block.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package input_pkg;

    // 1 ms debounce window and 1 s long-press time on the 48 MHz oscillator
    localparam int unsigned c_debounce_cycles_48m = 48000;
    localparam int unsigned c_long_cycles_48m     = 48000000;

    // Registered view of one debounced channel
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic long_press;
    } chan_out_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/input_debounce_if.sv
//==============================================================================
// Module : input_debounce_if
// Desc   : Pin-side inputs and fabric-side debounced outputs of input_debounce.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface input_debounce_if #(
    parameter int unsigned NCH = 4
);
    logic [NCH-1:0] in_i;
    logic [NCH-1:0] level_o;
    logic [NCH-1:0] rise_o;
    logic [NCH-1:0] fall_o;
    logic [NCH-1:0] long_o;

    modport master (
        output in_i,
        input  level_o,
        input  rise_o,
        input  fall_o,
        input  long_o
    );

    modport slave (
        input  in_i,
        output level_o,
        output rise_o,
        output fall_o,
        output long_o
    );
endinterface

`default_nettype wire

// File: rtl/debounce_chan.sv
//==============================================================================
// Module : debounce_chan
// Desc   : One channel: 2-flop sync, stability counter, long-press timer.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_chan
    import input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_48m,
    parameter int unsigned LONG_CYCLES     = c_long_cycles_48m
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      pin,
    output chan_out_t      evt
);

    localparam int unsigned c_dcnt_w = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned c_hcnt_w = cnt_width(LONG_CYCLES + 1);

    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hcnt_w-1:0] c_hcnt_max  = c_hcnt_w'(LONG_CYCLES);
    localparam logic [c_hcnt_w-1:0] c_hcnt_last = c_hcnt_w'(LONG_CYCLES - 1);

    logic                r_s1;
    logic                r_s2;
    logic [c_dcnt_w-1:0] r_dcnt;
    logic [c_hcnt_w-1:0] r_hcnt;
    logic                r_level;
    logic                r_rise;
    logic                r_fall;
    logic                r_long;

    logic                w_differ;
    logic                w_accept;
    logic [c_dcnt_w-1:0] w_dcnt_nxt;
    logic [c_hcnt_w-1:0] w_hcnt_nxt;
    logic                w_long_nxt;

    always_comb begin
        w_differ   = (r_s2 != r_level);
        w_accept   = w_differ && (r_dcnt == c_dcnt_last);
        w_dcnt_nxt = '0;
        w_hcnt_nxt = '0;
        w_long_nxt = 1'b0;

        // Any sample matching the current level throws away the partial count
        if (w_differ && !w_accept) begin
            w_dcnt_nxt = r_dcnt + 1'b1;
        end

        if (r_level) begin
            if (r_hcnt != c_hcnt_max) begin
                w_hcnt_nxt = r_hcnt + 1'b1;
                w_long_nxt = (r_hcnt == c_hcnt_last);
            end else begin
                w_hcnt_nxt = r_hcnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_dcnt  <= '0;
            r_hcnt  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_s1    <= pin;
            r_s2    <= r_s1;
            r_dcnt  <= w_dcnt_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_level <= w_accept ? r_s2 : r_level;
            r_rise  <= w_accept && r_s2;
            r_fall  <= w_accept && !r_s2;
            r_long  <= w_long_nxt;
        end
    end

    assign evt.level      = r_level;
    assign evt.rise       = r_rise;
    assign evt.fall       = r_fall;
    assign evt.long_press = r_long;

endmodule

`default_nettype wire

// File: rtl/input_debounce.sv
//==============================================================================
// Module : input_debounce
// Desc   : NCH independent synchronizing debouncers with edge/long-press pulses.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module input_debounce
    import input_pkg::*;
#(
    parameter int unsigned NCH             = 4,
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_48m,
    parameter int unsigned LONG_CYCLES     = c_long_cycles_48m
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input_debounce_if.slave    bus
);

    chan_out_t      w_evt [NCH];
    logic [NCH-1:0] w_level;
    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_fall;
    logic [NCH-1:0] w_long;

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .pin (bus.in_i[n]),
            .evt (w_evt[n])
        );

        assign w_level[n] = w_evt[n].level;
        assign w_rise[n]  = w_evt[n].rise;
        assign w_fall[n]  = w_evt[n].fall;
        assign w_long[n]  = w_evt[n].long_press;
    end

    assign bus.level_o = w_level;
    assign bus.rise_o  = w_rise;
    assign bus.fall_o  = w_fall;
    assign bus.long_o  = w_long;

endmodule

`default_nettype wire

// File: tb/tb_input_debounce.sv
//==============================================================================
// Module : tb_input_debounce
// Desc   : Randomized and directed bench for input_debounce (two builds).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_input_debounce;

    localparam int NCH  = 4;
    localparam int D_A  = 4;
    localparam int L_A  = 10;
    localparam int D_B  = 1;
    localparam int L_B  = 5;
    localparam int MAXT = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   t = 0;

    input_debounce_if #(.NCH(NCH)) bus_a ();
    input_debounce_if #(.NCH(NCH)) bus_b ();

    input_debounce #(.NCH(NCH), .DEBOUNCE_CYCLES(D_A), .LONG_CYCLES(L_A)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    input_debounce #(.NCH(NCH), .DEBOUNCE_CYCLES(D_B), .LONG_CYCLES(L_B)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    // Reference: history of pin values seen by the first sync flop, per edge
    logic [NCH-1:0] samp [2][MAXT];
    logic [NCH-1:0] m_lvl [2];
    logic [NCH-1:0] m_rise [2];
    logic [NCH-1:0] m_fall [2];
    logic [NCH-1:0] m_long [2];
    int             last_chg [2][NCH];
    int             last_rise [2][NCH];

    // Accept at edge t when the D newest synchronized samples (two edges stale)
    // all oppose the level and no acceptance happened within those D edges.
    task automatic model_step(input int u, input logic [NCH-1:0] inv, input int d, input int l);
        for (int c = 0; c < NCH; c++) begin
            logic acc;
            m_rise[u][c] = 1'b0;
            m_fall[u][c] = 1'b0;
            m_long[u][c] = 1'b0;
            if (rst) begin
                samp[u][t][c] = 1'b0;
                if (t > 0) samp[u][t-1][c] = 1'b0;
                m_lvl[u][c]     = 1'b0;
                last_chg[u][c]  = t;
                last_rise[u][c] = -1000000;
            end else begin
                samp[u][t][c] = inv[c];
                m_long[u][c]  = m_lvl[u][c] && (last_rise[u][c] == t - l);
                acc = (t - last_chg[u][c] >= d);
                for (int j = 0; j < d; j++) begin
                    if (t - 2 - j < 0) acc = 1'b0;
                    else if (samp[u][t-2-j][c] !== !m_lvl[u][c]) acc = 1'b0;
                end
                if (acc) begin
                    m_lvl[u][c]    = !m_lvl[u][c];
                    last_chg[u][c] = t;
                    if (m_lvl[u][c]) begin
                        m_rise[u][c]    = 1'b1;
                        last_rise[u][c] = t;
                    end else begin
                        m_fall[u][c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        if (t >= MAXT) begin
            $display("FAIL cycle_budget t=%0d limit=%0d", t, MAXT);
            $fatal(1, "cycle budget exhausted");
        end
        model_step(0, bus_a.in_i, D_A, L_A);
        model_step(1, bus_b.in_i, D_B, L_B);
        #1;
    endtask

    task automatic test_reset();
        bus_a.in_i = '0;
        bus_b.in_i = '0;
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o,
             bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=00000000",
                {bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o,
                 bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o});
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o,
                 bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o} !== 32'h0) begin
                n_err++;
                $display("FAIL idle t=%0d got=%h exp=00000000", t,
                    {bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o,
                     bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o});
            end
        end
    endtask

    task automatic test_press();
        int k;
        int re;
        bus_a.in_i[0] = 1'b1;
        k  = t + 1;
        re = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o}
                !== {m_lvl[0], m_rise[0], m_fall[0], m_long[0]}) begin
                n_err++;
                $display("FAIL press t=%0d got=%h exp=%h", t,
                    {bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o},
                    {m_lvl[0], m_rise[0], m_fall[0], m_long[0]});
            end
            if (bus_a.rise_o[0] && re < 0) re = t;
        end
        n_cmp++;
        if (re - k != 5) begin
            n_err++;
            $display("FAIL press_latency got=%0d exp=5 edges after sample", re - k);
        end
        n_cmp++;
        if (bus_a.level_o !== 4'b0001) begin
            n_err++;
            $display("FAIL press_level got=%b exp=0001", bus_a.level_o);
        end
        bus_a.in_i[0] = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_bounce();
        int n_edge;
        int n_rise;
        n_edge = 0;
        bus_a.in_i[1] = 1'b1;
        repeat (3) tick();
        bus_a.in_i[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_a.level_o[1] || bus_a.rise_o[1] || bus_a.fall_o[1]) n_edge++;
            n_cmp++;
            if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o}
                !== {m_lvl[0], m_rise[0], m_fall[0]}) begin
                n_err++;
                $display("FAIL bounce3 t=%0d got=%h exp=%h", t,
                    {bus_a.level_o, bus_a.rise_o, bus_a.fall_o},
                    {m_lvl[0], m_rise[0], m_fall[0]});
            end
        end
        n_cmp++;
        if (n_edge != 0) begin
            n_err++;
            $display("FAIL bounce3_activity got=%0d exp=0", n_edge);
        end
        n_rise = 0;
        bus_a.in_i[1] = 1'b1;
        repeat (4) tick();
        bus_a.in_i[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_a.rise_o[1]) n_rise++;
            n_cmp++;
            if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o}
                !== {m_lvl[0], m_rise[0], m_fall[0]}) begin
                n_err++;
                $display("FAIL bounce4 t=%0d got=%h exp=%h", t,
                    {bus_a.level_o, bus_a.rise_o, bus_a.fall_o},
                    {m_lvl[0], m_rise[0], m_fall[0]});
            end
        end
        n_cmp++;
        if (n_rise != 1) begin
            n_err++;
            $display("FAIL bounce4_rise got=%0d exp=1", n_rise);
        end
    endtask

    task automatic test_long_press();
        int k;
        int re;
        int le;
        int fe;
        int n_long;
        re = -1; le = -1; fe = -1; n_long = 0;
        bus_a.in_i[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_a.rise_o[2] && re < 0) re = t;
            if (bus_a.long_o[2]) begin n_long++; le = t; end
        end
        bus_a.in_i[2] = 1'b0;
        k = t + 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_a.fall_o[2] && fe < 0) fe = t;
            if (bus_a.long_o[2]) n_long++;
            n_cmp++;
            if ({bus_a.level_o, bus_a.fall_o, bus_a.long_o}
                !== {m_lvl[0], m_fall[0], m_long[0]}) begin
                n_err++;
                $display("FAIL release t=%0d got=%h exp=%h", t,
                    {bus_a.level_o, bus_a.fall_o, bus_a.long_o},
                    {m_lvl[0], m_fall[0], m_long[0]});
            end
        end
        n_cmp++;
        if (le - re != L_A) begin
            n_err++;
            $display("FAIL long_delay got=%0d exp=%0d", le - re, L_A);
        end
        n_cmp++;
        if (n_long != 1) begin
            n_err++;
            $display("FAIL long_count got=%0d exp=1", n_long);
        end
        n_cmp++;
        if (fe - k != 5) begin
            n_err++;
            $display("FAIL fall_latency got=%0d exp=5", fe - k);
        end
    endtask

    task automatic test_fast_toggle();
        int n_evt;
        logic last_rise_seen;
        logic alt_ok;
        n_evt = 0;
        last_rise_seen = 1'b0;
        alt_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0 && i < 36) bus_b.in_i[3] = !bus_b.in_i[3];
            tick();
            if (bus_b.rise_o[3]) begin
                if (last_rise_seen) alt_ok = 1'b0;
                last_rise_seen = 1'b1;
                n_evt++;
            end
            if (bus_b.fall_o[3]) begin
                if (!last_rise_seen) alt_ok = 1'b0;
                last_rise_seen = 1'b0;
                n_evt++;
            end
            n_cmp++;
            if ({bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o}
                !== {m_lvl[1], m_rise[1], m_fall[1], m_long[1]}) begin
                n_err++;
                $display("FAIL fast t=%0d got=%h exp=%h", t,
                    {bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o},
                    {m_lvl[1], m_rise[1], m_fall[1], m_long[1]});
            end
        end
        n_cmp++;
        if (n_evt != 12 || !alt_ok) begin
            n_err++;
            $display("FAIL fast_events got=%0d alt=%0b exp=12 alt=1", n_evt, alt_ok);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int re;
        re = -1;
        bus_a.in_i[0] = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (bus_a.level_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL premid_level got=%b exp=1", bus_a.level_o[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o} !== 16'h0) begin
            n_err++;
            $display("FAIL mid_reset got=%h exp=0000",
                {bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o});
        end
        k = t + 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus_a.rise_o[0] && re < 0) re = t;
            n_cmp++;
            if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o}
                !== {m_lvl[0], m_rise[0], m_fall[0], m_long[0]}) begin
                n_err++;
                $display("FAIL post_reset t=%0d got=%h exp=%h", t,
                    {bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o},
                    {m_lvl[0], m_rise[0], m_fall[0], m_long[0]});
            end
        end
        n_cmp++;
        if (re - k != 5) begin
            n_err++;
            $display("FAIL post_reset_rise got=%0d exp=5", re - k);
        end
        bus_a.in_i[0] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int hold_a [NCH];
        int hold_b [NCH];
        for (int c = 0; c < NCH; c++) begin
            hold_a[c] = 0;
            hold_b[c] = 0;
        end
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold_a[c] == 0) begin
                    bus_a.in_i[c] = !bus_a.in_i[c];
                    hold_a[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 25))
                                                            : int'($urandom_range(1, 6));
                end else begin
                    hold_a[c]--;
                end
                if (hold_b[c] == 0) begin
                    bus_b.in_i[c] = !bus_b.in_i[c];
                    hold_b[c] = int'($urandom_range(0, 9));
                end else begin
                    hold_b[c]--;
                end
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
            n_cmp++;
            if ({bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o,
                 bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o}
                !== {m_lvl[0], m_rise[0], m_fall[0], m_long[0],
                     m_lvl[1], m_rise[1], m_fall[1], m_long[1]}) begin
                n_err++;
                $display("FAIL random t=%0d got=%h exp=%h", t,
                    {bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.long_o,
                     bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.long_o},
                    {m_lvl[0], m_rise[0], m_fall[0], m_long[0],
                     m_lvl[1], m_rise[1], m_fall[1], m_long[1]});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus_a.in_i = '0;
        bus_b.in_i = '0;
        test_reset();
        test_press();
        test_bounce();
        test_long_press();
        test_fast_toggle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
